sha2_core: RTL and testbench
============================

# sha2_core

Parametrised SHA-224/SHA-256 compression engine and the successor to the single-round, single-block hash core. It accepts pre-padded 512-bit blocks over a valid/ready handshake and chains multi-block messages through a `first` flag. It performs `UNROLL` rounds per clock and presents a held digest with a done flag. It sits between the software-side padding/message buffer and any consumer of the 256-bit digest.

## Interface
- `UNROLL`, default 1: rounds per clock. Legal values are 1, 2, 4 and 8, all divisors of 64.
- `clock` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `block` is presented.
- `in_ready` output, 1 bit: engine is idle and will accept a block.
- `block` input, 512 bits: padded block. Word 0 = `block[511:480]`.
- `first` input, 1 bit: block starts a new message and is qualified by `in_valid`.
- `sha224` input, 1 bit: mode select, sampled only on an accepted block with `first=1`.
- `abort` input, 1 bit: synchronous cancel of the current block.
- `busy` output, 1 bit: a block is being compressed.
- `digest_valid` output, 1 bit: `digest` holds the result of the last completed block.
- `digest` output, 256 bits: H0 sits at `[255:224]`. In SHA-224 mode, `[255:32]` = H0..H6 and `[31:0]` = 0.

## Operation
- States are IDLE, ROUND and FINAL. `in_ready` = (state == IDLE). `busy` = (state != IDLE).
- **Accept** occurs on `in_valid && in_ready`. On accept:
  - Latch `block` into the 16-word schedule window.
  - Clear `digest_valid`.
  - Reset the round counter to 0 and go to ROUND.
  - If `first=1`, or if `chain_ok=0`: latch the `sha224` mode, set H and a..h to the IV for that mode (SHA-224 IV when `sha224=1`), and set `chain_ok=1`.
  - Otherwise, load a..h from the current H and keep the latched mode.
- **ROUND**: each cycle runs rounds t..t+UNROLL-1 as a combinational chain of `UNROLL` round instances.
  - For t<16 the schedule word W[t] is the window word.
  - For t≥16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], all mod 2^32.
  - The window shifts by `UNROLL` words per cycle. Only 16 words are stored; there is no 64-entry array.
  - The counter advances by `UNROLL`. When t+UNROLL == 64, go to FINAL.
- **FINAL**: Hi <= Hi + working variable, mod 2^32. Set `digest_valid=1` and go to IDLE.
- `digest_valid` stays high until the next accept or abort. `digest` changes only in FINAL and on an accept with IV load.
- **abort** in ROUND or FINAL: go to IDLE, clear `digest_valid` and `chain_ok`, and leave H unchanged. The next block is hashed from the IV regardless of `first`. `abort` in IDLE only clears `chain_ok` and `digest_valid`.
- If `abort` and `in_valid` are asserted in the same IDLE cycle, abort wins and the block is not accepted.
- The `block`, `first` and `sha224` inputs are don't-care while `in_ready=0`.

## Timing
- Reset values: state IDLE, so `in_ready=1` and `busy=0`. `digest_valid=0`, `chain_ok=0`, mode SHA-256, and H = SHA-256 IV, so `digest` = 6a09e667…5be0cd19.
- Reset asserted mid-block discards all state immediately. No partial digest is visible.
- Latency: if the accept is at edge 0, then edges 1..64/UNROLL run rounds and edge 64/UNROLL+1 is FINAL.
  - `digest_valid` and `in_ready` are high after FINAL: 65 cycles for UNROLL=1, 9 cycles for UNROLL=8.
- Back-to-back blocks: the next block may be accepted in the first cycle `in_ready` is high. Throughput is one block per 64/UNROLL+2 cycles.

## Structure
- `sha2_pkg` holds:
  - the K[0:63] table;
  - the SHA-256 and SHA-224 IV arrays;
  - the σ0, σ1, Σ0, Σ1, Ch and Maj functions;
  - the state enum;
  - a `sha2_vars_t` struct for a..h.
- Sub-module `sha256_round` is purely combinational. Inputs are `sha2_vars_t`, `k` and `w`; output is the next `sha2_vars_t`. It is instantiated `UNROLL` times via generate.
- The schedule-expansion logic stays in `sha2_core`.

## Test plan
- "abc" single block (61626380, 13 zero words, 00000018), `first=1`, SHA-256 → digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with `digest_valid` exactly 65 cycles after accept for UNROLL=1.
- Same block with `sha224=1` → digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
- 56-character message "abcdbcdecdef…nopq" sent as two blocks (`first`=1 then 0, back-to-back) → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. Repeat at UNROLL=1, 2, 4 and 8 and check the 64/UNROLL+1 latency each time.
- Abort at round 30 of block 1 of the two-block message, then send block 2 with `first=0` → hashed from the IV and equal to the standalone single-block hash of block 2. `digest_valid` is low between the abort and the completion of block 2.
- Hold `in_valid=1` continuously: `in_ready` is low throughout ROUND/FINAL and changes to `block` mid-hash do not affect the result. Assert reset mid-hash → `digest` = SHA-256 IV, `digest_valid=0`, `in_ready=1`.
- Empty message (80000000, then zeros, length 0) → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-224/SHA-256 definitions: round constants, initial hash values,
// the compression helper functions, FSM states and the working-variable bundle.
package sha2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StFinal
  } sha2_state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } sha2_vars_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // H0 occupies the most significant word, matching the sha2_vars_t field order.
  localparam logic [255:0] Sha256Iv = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] Sha224Iv = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    logic [63:0] dbl;
    dbl = {x, x} >> n;
    return dbl[31:0];
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic sha2_vars_t add_vars(input sha2_vars_t x, input sha2_vars_t y);
    sha2_vars_t s;
    s.a = x.a + y.a;
    s.b = x.b + y.b;
    s.c = x.c + y.c;
    s.d = x.d + y.d;
    s.e = x.e + y.e;
    s.f = x.f + y.f;
    s.g = x.g + y.g;
    s.h = x.h + y.h;
    return s;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round, purely combinational so several can be chained
// within a single clock.
module sha256_round
  import sha2_pkg::*;
(
  input  sha2_vars_t  i_vars,
  input  logic [31:0] i_k,
  input  logic [31:0] i_w,
  output sha2_vars_t  o_vars
);

  logic [31:0] w_t1;
  logic [31:0] w_t2;

  assign w_t1 = i_vars.h + big_sigma1(i_vars.e) + ch(i_vars.e, i_vars.f, i_vars.g) + i_k + i_w;
  assign w_t2 = big_sigma0(i_vars.a) + maj(i_vars.a, i_vars.b, i_vars.c);

  assign o_vars = {w_t1 + w_t2, i_vars.a, i_vars.b, i_vars.c,
                   i_vars.d + w_t1, i_vars.e, i_vars.f, i_vars.g};

endmodule

// File: rtl/sha2_core.sv
// SHA-224/SHA-256 block compression engine running UNROLL rounds per clock,
// with multi-block chaining and a held digest.
module sha2_core
  import sha2_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block,
  input  logic         first,
  input  logic         sha224,
  input  logic         abort,
  output logic         busy,
  output logic         digest_valid,
  output logic [255:0] digest
);

  localparam logic [5:0] LastRound = 6'(64 - UNROLL);
  localparam logic [5:0] RoundStep = 6'(UNROLL);
  localparam int unsigned NumSched = 16 + UNROLL;

  sha2_state_e       r_state, w_state_next;
  sha2_vars_t        r_vars, w_vars_next;
  sha2_vars_t        r_h, w_h_next;
  logic [15:0][31:0] r_window, w_window_next;
  logic [5:0]        r_round, w_round_next;
  logic              r_chain_ok, w_chain_ok_next;
  logic              r_sha224, w_sha224_next;
  logic              r_digest_valid, w_digest_valid_next;

  logic [31:0]       w_sched [NumSched];
  sha2_vars_t        w_chain [UNROLL + 1];
  sha2_vars_t        w_iv;

  // Window holds W[t..t+15]; extend it by UNROLL words so each round in this
  // cycle has its word and the shifted window is ready for the next cycle.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_sched[i] = r_window[i];
    end
    for (int j = 0; j < int'(UNROLL); j++) begin
      w_sched[16 + j] = small_sigma1(w_sched[14 + j]) + w_sched[9 + j] +
                        small_sigma0(w_sched[1 + j]) + w_sched[j];
    end
  end

  assign w_chain[0] = r_vars;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    logic [5:0] w_t;
    assign w_t = r_round + 6'(g);
    sha256_round u_round (
      .i_vars (w_chain[g]),
      .i_k    (K[w_t]),
      .i_w    (w_sched[g]),
      .o_vars (w_chain[g + 1])
    );
  end

  assign w_iv = sha224 ? sha2_vars_t'(Sha224Iv) : sha2_vars_t'(Sha256Iv);

  always_comb begin
    w_state_next        = r_state;
    w_vars_next         = r_vars;
    w_h_next            = r_h;
    w_window_next       = r_window;
    w_round_next        = r_round;
    w_chain_ok_next     = r_chain_ok;
    w_sha224_next       = r_sha224;
    w_digest_valid_next = r_digest_valid;

    if (abort) begin
      // Abort wins over a simultaneous block offer; H is deliberately left alone.
      w_state_next        = StIdle;
      w_digest_valid_next = 1'b0;
      w_chain_ok_next     = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            for (int i = 0; i < 16; i++) begin
              w_window_next[i] = block[511 - 32 * i -: 32];
            end
            w_digest_valid_next = 1'b0;
            w_round_next        = '0;
            w_state_next        = StRound;
            if (first || !r_chain_ok) begin
              w_sha224_next   = sha224;
              w_h_next        = w_iv;
              w_vars_next     = w_iv;
              w_chain_ok_next = 1'b1;
            end else begin
              w_vars_next = r_h;
            end
          end
        end
        StRound: begin
          w_vars_next = w_chain[UNROLL];
          for (int i = 0; i < 16; i++) begin
            w_window_next[i] = w_sched[i + int'(UNROLL)];
          end
          w_round_next = r_round + RoundStep;
          if (r_round == LastRound) begin
            w_state_next = StFinal;
          end
        end
        StFinal: begin
          w_h_next            = add_vars(r_h, r_vars);
          w_digest_valid_next = 1'b1;
          w_state_next        = StIdle;
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vars         <= '0;
      r_h            <= sha2_vars_t'(Sha256Iv);
      r_window       <= '0;
      r_round        <= '0;
      r_chain_ok     <= 1'b0;
      r_sha224       <= 1'b0;
      r_digest_valid <= 1'b0;
    end else begin
      r_vars         <= w_vars_next;
      r_h            <= w_h_next;
      r_window       <= w_window_next;
      r_round        <= w_round_next;
      r_chain_ok     <= w_chain_ok_next;
      r_sha224       <= w_sha224_next;
      r_digest_valid <= w_digest_valid_next;
    end
  end

  assign in_ready     = (r_state == StIdle);
  assign busy         = (r_state != StIdle);
  assign digest_valid = r_digest_valid;
  // SHA-224 truncates to H0..H6; the unused low word reads as zero.
  assign digest       = {r_h[255:32], r_sha224 ? 32'h0 : r_h.h};

endmodule

// File: tb/tb_sha2_core.sv
// Bench for sha2_core: four instances (UNROLL 1/2/4/8) checked against known
// vectors and a plain 64-word SHA-256 compression model.
module tb_sha2_core;

  localparam int NumDut = 4;

  localparam logic [255:0] Iv256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] Iv224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [255:0] Abc256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] Abc224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] Two256 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] Empty256 = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  localparam logic [511:0] BlkAbc = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BlkEmpty = {32'h80000000, 480'h0};
  localparam logic [511:0] BlkTwo1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BlkTwo2 = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic                clock = 1'b0;
  logic                reset;
  logic [NumDut-1:0]   in_valid;
  logic [NumDut-1:0]   abort;
  logic [NumDut-1:0]   in_ready;
  logic [NumDut-1:0]   busy;
  logic [NumDut-1:0]   digest_valid;
  logic [511:0]        block;
  logic                first;
  logic                sha224;
  logic [255:0]        digest [NumDut];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: chained H, chain-valid flag, latched mode.
  logic [255:0] m_h;
  bit           m_chain;
  bit           m_224;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    sha2_core #(.UNROLL(1 << g)) u_dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid[g]),
      .in_ready     (in_ready[g]),
      .block        (block),
      .first        (first),
      .sha224       (sha224),
      .abort        (abort[g]),
      .busy         (busy[g]),
      .digest_valid (digest_valid[g]),
      .digest       (digest[g])
    );
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int unsigned n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] hv [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] hout;
    for (int i = 0; i < 8; i++) begin
      hv[i] = hin[255 - 32 * i -: 32];
      v[i]  = hv[i];
    end
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32 * t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int t = 0; t < 64; t++) begin
      s1 = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      s0 = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[255 - 32 * i -: 32] = hv[i] + v[i];
    return hout;
  endfunction

  function automatic logic [255:0] model_digest();
    logic [255:0] d;
    d = m_h;
    if (m_224) d[31:0] = 32'h0;
    return d;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32 * i +: 32] = $urandom;
    return b;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_apply(input logic [511:0] blk, input logic f, input logic s);
    if (f || !m_chain) begin
      m_224   = s;
      m_h     = s ? Iv224 : Iv256;
      m_chain = 1'b1;
    end
    m_h = compress(m_h, blk);
  endtask

  task automatic model_reset();
    m_h = Iv256;
    m_chain = 1'b0;
    m_224 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    model_reset();
  endtask

  // Offer a block on the first cycle in_ready is seen high; returns after the accept edge.
  task automatic accept(input int u, input logic [511:0] blk, input logic f, input logic s);
    int guard = 0;
    while (!in_ready[u] && guard < 300) begin
      tick();
      guard++;
    end
    check($sformatf("ready_u%0d", u), 256'(in_ready[u]), 256'(1));
    block = blk;
    first = f;
    sha224 = s;
    in_valid[u] = 1'b1;
    tick();
    in_valid[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, output int lat);
    lat = 0;
    while (!digest_valid[u] && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_block(input int u, input string tag, input logic [511:0] blk,
                           input logic f, input logic s);
    int lat;
    model_apply(blk, f, s);
    accept(u, blk, f, s);
    wait_done(u, lat);
    check($sformatf("%s_lat_u%0d", tag, u), 256'(lat), 256'(64 / (1 << u) + 1));
    check($sformatf("%s_dig_u%0d", tag, u), digest[u], model_digest());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int bad_ready;
    in_valid = '0;
    abort = '0;
    block = '0;
    first = 1'b0;
    sha224 = 1'b0;
    reset = 1'b0;
    model_reset();

    for (int u = 0; u < NumDut; u++) begin
      do_reset();
      check($sformatf("rst_ready_u%0d", u), 256'(in_ready[u]), 256'(1));
      check($sformatf("rst_busy_u%0d", u), 256'(busy[u]), 256'(0));
      check($sformatf("rst_dv_u%0d", u), 256'(digest_valid[u]), 256'(0));
      check($sformatf("rst_digest_u%0d", u), digest[u], Iv256);

      run_block(u, "abc256", BlkAbc, 1'b1, 1'b0);
      check($sformatf("abc256_kat_u%0d", u), digest[u], Abc256);
      run_block(u, "abc224", BlkAbc, 1'b1, 1'b1);
      check($sformatf("abc224_kat_u%0d", u), digest[u], Abc224);

      // Back-to-back two-block message.
      run_block(u, "two_b1", BlkTwo1, 1'b1, 1'b0);
      run_block(u, "two_b2", BlkTwo2, 1'b0, 1'b0);
      check($sformatf("two_kat_u%0d", u), digest[u], Two256);

      // Abort partway through block 1, then block 2 with first=0 restarts from the IV.
      model_apply(BlkTwo1, 1'b1, 1'b0);
      accept(u, BlkTwo1, 1'b1, 1'b0);
      for (int i = 0; i < 30 / (1 << u); i++) tick();
      abort[u] = 1'b1;
      tick();
      abort[u] = 1'b0;
      m_chain = 1'b0;
      check($sformatf("abort_dv_u%0d", u), 256'(digest_valid[u]), 256'(0));
      check($sformatf("abort_ready_u%0d", u), 256'(in_ready[u]), 256'(1));
      tick();
      tick();
      check($sformatf("abort_dv_hold_u%0d", u), 256'(digest_valid[u]), 256'(0));
      run_block(u, "post_abort", BlkTwo2, 1'b0, 1'b0);
      check($sformatf("post_abort_iv_u%0d", u), digest[u], compress(Iv256, BlkTwo2));

      // Abort and in_valid together in IDLE: block must be refused.
      block = rand_block();
      first = 1'b1;
      in_valid[u] = 1'b1;
      abort[u] = 1'b1;
      tick();
      in_valid[u] = 1'b0;
      abort[u] = 1'b0;
      m_chain = 1'b0;
      check($sformatf("idle_abort_busy_u%0d", u), 256'(busy[u]), 256'(0));
      check($sformatf("idle_abort_dv_u%0d", u), 256'(digest_valid[u]), 256'(0));

      for (int n = 0; n < 6; n++) begin
        run_block(u, $sformatf("rnd%0d", n), rand_block(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      end

      run_block(u, "empty", BlkEmpty, 1'b1, 1'b0);
      check($sformatf("empty_kat_u%0d", u), digest[u], Empty256);

      // in_valid held high with block churning during the hash.
      model_apply(BlkAbc, 1'b1, 1'b0);
      block = BlkAbc;
      first = 1'b1;
      sha224 = 1'b0;
      in_valid[u] = 1'b1;
      tick();
      lat = 0;
      bad_ready = 0;
      while (!digest_valid[u] && lat < 300) begin
        if (in_ready[u]) bad_ready++;
        block = rand_block();
        first = 1'($urandom_range(0, 1));
        sha224 = 1'($urandom_range(0, 1));
        tick();
        lat++;
      end
      in_valid[u] = 1'b0;
      check($sformatf("hold_ready_low_u%0d", u), 256'(bad_ready), 256'(0));
      check($sformatf("hold_lat_u%0d", u), 256'(lat), 256'(64 / (1 << u) + 1));
      check($sformatf("hold_dig_u%0d", u), digest[u], Abc256);

      // Reset asserted mid-hash.
      accept(u, rand_block(), 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b0;
      #1;
      check($sformatf("midrst_digest_u%0d", u), digest[u], Iv256);
      check($sformatf("midrst_dv_u%0d", u), 256'(digest_valid[u]), 256'(0));
      check($sformatf("midrst_ready_u%0d", u), 256'(in_ready[u]), 256'(1));
      tick();
      reset = 1'b1;
      model_reset();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
